// File: rtl/riscv_pkg.sv
// Shared types and helpers for the branch prediction logic.
package riscv_pkg;

  // Widest tag any legal IDX_W/TAG_W split of a 32-bit word-aligned PC can need.
  localparam int TAG_MAX_W = 30;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  // Two-bit saturating counter step toward the observed outcome.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: one combinational read port for Fetch, one
// synchronous read-modify-write port for Execute training, synchronous clear.
module btb_table
  import riscv_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic             wr_jump,
  input  logic [31:0]      wr_target
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid_q  [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];

  logic wr_hit;

  // Hit check for the training port, against the entry as it is before this edge.
  always_comb begin
    wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  // Fetch read port: pre-update contents, so a same-cycle write is seen next cycle.
  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = TAG_MAX_W'(tag_q[rd_idx]);
    rd_entry.target = target_q[rd_idx];
    rd_entry.ctr    = ctr_q[rd_idx];
  end

  // Control state: valid bits and counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_SNT;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
      end else if (wr_taken) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= wr_jump ? CTR_ST : CTR_WT;
      end
    end
  end

  // Payload: tag and target only change on a taken resolve (hit retarget or
  // allocation); on a hit the tag rewrite is the same value.
  always_ff @(posedge clk) begin
    if (wr_en && wr_taken) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB lookup in Fetch, training and mispredict
// detection in Execute, plus saturating performance counters.
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCF,
  output logic             PredTakenF,
  output logic [31:0]      PredTargetF,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             TakenE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      PCPlus4E,
  input  logic             PredTakenE,
  input  logic [31:0]      PredTargetE,
  input  logic             FlushE,
  output logic             MispredictE,
  output logic [31:0]      RedirectPCE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  btb_entry_t       entry_f;
  logic             hit_f;
  logic             resolve_e;
  logic             wr_en;
  logic             unused_bits;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[TAG_HI:TAG_LO];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[TAG_HI:TAG_LO];

  // PC bits outside index/tag and the spare tag field bits carry no information here.
  assign unused_bits = ^{PCF, PCE, entry_f.tag};

  // Training is blocked while reset is high so the clear always wins.
  assign wr_en = resolve_e & ~reset;

  btb_table #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (idx_f),
    .rd_entry  (entry_f),
    .wr_en     (wr_en),
    .wr_idx    (idx_e),
    .wr_tag    (tag_e),
    .wr_taken  (TakenE),
    .wr_jump   (JumpE),
    .wr_target (PCTargetE)
  );

  // Fetch lookup: zero latency from PCF, forced quiet during reset.
  always_comb begin
    hit_f       = entry_f.valid && (entry_f.tag[TAG_W-1:0] == tag_f);
    PredTakenF  = 1'b0;
    PredTargetF = '0;
    if (!reset && hit_f) begin
      PredTakenF  = entry_f.ctr[1];
      PredTargetF = entry_f.target;
    end
  end

  // Execute resolve: direction mismatch, or correct taken guess with a stale target.
  always_comb begin
    resolve_e   = (BranchE | JumpE) & ~FlushE;
    MispredictE = 1'b0;
    RedirectPCE = '0;
    if (!reset) begin
      MispredictE = resolve_e &&
                    ((PredTakenE != TakenE) ||
                     (PredTakenE && TakenE && (PredTargetE != PCTargetE)));
      RedirectPCE = TakenE ? PCTargetE : PCPlus4E;
    end
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (resolve_e && (BranchCount != {CNT_W{1'b1}}))
        BranchCount <= BranchCount + CNT_W'(1);
      if (MispredictE && (MispredCount != {CNT_W{1'b1}}))
        MispredCount <= MispredCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE, JumpE, TakenE;
  logic [31:0] PCE, PCTargetE, PCPlus4E;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        FlushE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCount, MispredCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(6), .TAG_W(8), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .PCF          (PCF),
    .PredTakenF   (PredTakenF),
    .PredTargetF  (PredTargetF),
    .BranchE      (BranchE),
    .JumpE        (JumpE),
    .TakenE       (TakenE),
    .PCE          (PCE),
    .PCTargetE    (PCTargetE),
    .PCPlus4E     (PCPlus4E),
    .PredTakenE   (PredTakenE),
    .PredTargetE  (PredTargetE),
    .FlushE       (FlushE),
    .MispredictE  (MispredictE),
    .RedirectPCE  (RedirectPCE),
    .BranchCount  (BranchCount),
    .MispredCount (MispredCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_e();
    BranchE = 0; JumpE = 0; TakenE = 0; FlushE = 0;
    PCE = 0; PCTargetE = 0; PCPlus4E = 0; PredTakenE = 0; PredTargetE = 0;
  endtask

  task automatic resolve(input logic br, input logic jp, input logic tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic fl);
    BranchE = br; JumpE = jp; TakenE = tk; PCE = pc; PCTargetE = tgt;
    PCPlus4E = pc + 32'd4; PredTakenE = ptk; PredTargetE = ptgt; FlushE = fl;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; PCF = 32'h40; idle_e();
    resolve(1, 0, 1, 32'h40, 32'h20, 0, 0, 0);
    n_cmp++; if (MispredictE !== 1'b0) begin n_err++; $display("FAIL rst_mispred got=%b exp=0", MispredictE); end
    n_cmp++; if (RedirectPCE !== 32'h0) begin n_err++; $display("FAIL rst_redirect got=%h exp=0", RedirectPCE); end
    tick();
    reset = 0; idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL rst_predtaken got=%b exp=0", PredTakenF); end
    n_cmp++; if (PredTargetF !== 32'h0) begin n_err++; $display("FAIL rst_predtarget got=%h exp=0", PredTargetF); end
    n_cmp++; if (BranchCount !== 32'd0) begin n_err++; $display("FAIL rst_bcount got=%0d exp=0", BranchCount); end
    n_cmp++; if (MispredCount !== 32'd0) begin n_err++; $display("FAIL rst_mcount got=%0d exp=0", MispredCount); end
  endtask

  task automatic test_branch_train();
    PCF = 32'h40;
    resolve(1, 0, 1, 32'h40, 32'h20, 0, 0, 0);
    n_cmp++; if (MispredictE !== 1'b1) begin n_err++; $display("FAIL train_mispred got=%b exp=1", MispredictE); end
    n_cmp++; if (RedirectPCE !== 32'h20) begin n_err++; $display("FAIL train_redirect got=%h exp=20", RedirectPCE); end
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL train_same_cycle got=%b exp=0", PredTakenF); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b1) begin n_err++; $display("FAIL train_predtaken got=%b exp=1", PredTakenF); end
    n_cmp++; if (PredTargetF !== 32'h20) begin n_err++; $display("FAIL train_predtarget got=%h exp=20", PredTargetF); end
    n_cmp++; if (BranchCount !== 32'd1) begin n_err++; $display("FAIL train_bcount got=%0d exp=1", BranchCount); end
    n_cmp++; if (MispredCount !== 32'd1) begin n_err++; $display("FAIL train_mcount got=%0d exp=1", MispredCount); end
  endtask

  task automatic test_not_taken();
    PCF = 32'h40;
    resolve(1, 0, 0, 32'h40, 32'h20, 1, 32'h20, 0);  // ctr 10 -> 01
    n_cmp++; if (MispredictE !== 1'b1) begin n_err++; $display("FAIL nt1_mispred got=%b exp=1", MispredictE); end
    n_cmp++; if (RedirectPCE !== 32'h44) begin n_err++; $display("FAIL nt1_redirect got=%h exp=44", RedirectPCE); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL nt1_predtaken got=%b exp=0", PredTakenF); end
    n_cmp++; if (PredTargetF !== 32'h20) begin n_err++; $display("FAIL nt1_predtarget got=%h exp=20", PredTargetF); end
    resolve(1, 0, 0, 32'h40, 32'h20, 0, 32'h20, 0);  // ctr 01 -> 00
    n_cmp++; if (MispredictE !== 1'b0) begin n_err++; $display("FAIL nt2_mispred got=%b exp=0", MispredictE); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL nt2_predtaken got=%b exp=0", PredTakenF); end
    n_cmp++; if (BranchCount !== 32'd3) begin n_err++; $display("FAIL nt2_bcount got=%0d exp=3", BranchCount); end
    n_cmp++; if (MispredCount !== 32'd2) begin n_err++; $display("FAIL nt2_mcount got=%0d exp=2", MispredCount); end
    resolve(1, 0, 0, 32'h40, 32'h20, 0, 32'h20, 0);  // 00 holds
    tick();
    resolve(1, 0, 1, 32'h40, 32'h20, 0, 32'h20, 0);  // 00 -> 01
    n_cmp++; if (MispredictE !== 1'b1) begin n_err++; $display("FAIL sat_mispred got=%b exp=1", MispredictE); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL sat_predtaken got=%b exp=0", PredTakenF); end
    n_cmp++; if (PredTargetF !== 32'h20) begin n_err++; $display("FAIL sat_predtarget got=%h exp=20", PredTargetF); end
    n_cmp++; if (BranchCount !== 32'd5) begin n_err++; $display("FAIL sat_bcount got=%0d exp=5", BranchCount); end
    n_cmp++; if (MispredCount !== 32'd3) begin n_err++; $display("FAIL sat_mcount got=%0d exp=3", MispredCount); end
  endtask

  task automatic test_jalr();
    PCF = 32'h80;
    resolve(0, 1, 1, 32'h80, 32'h100, 0, 0, 0);       // allocate ctr=11
    n_cmp++; if (MispredictE !== 1'b1) begin n_err++; $display("FAIL jalr_alloc_mispred got=%b exp=1", MispredictE); end
    n_cmp++; if (RedirectPCE !== 32'h100) begin n_err++; $display("FAIL jalr_alloc_redirect got=%h exp=100", RedirectPCE); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b1) begin n_err++; $display("FAIL jalr_predtaken got=%b exp=1", PredTakenF); end
    n_cmp++; if (PredTargetF !== 32'h100) begin n_err++; $display("FAIL jalr_predtarget got=%h exp=100", PredTargetF); end
    resolve(1, 0, 0, 32'h80, 32'h100, 1, 32'h100, 0); // 11 -> 10, still taken
    n_cmp++; if (RedirectPCE !== 32'h84) begin n_err++; $display("FAIL jalr_nt_redirect got=%h exp=84", RedirectPCE); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b1) begin n_err++; $display("FAIL jalr_alloc_st got=%b exp=1", PredTakenF); end
    resolve(0, 1, 1, 32'h80, 32'h200, 1, 32'h100, 0);
    n_cmp++; if (MispredictE !== 1'b1) begin n_err++; $display("FAIL jalr_retgt_mispred got=%b exp=1", MispredictE); end
    n_cmp++; if (RedirectPCE !== 32'h200) begin n_err++; $display("FAIL jalr_retgt_redirect got=%h exp=200", RedirectPCE); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTargetF !== 32'h200) begin n_err++; $display("FAIL jalr_newtgt got=%h exp=200", PredTargetF); end
    resolve(0, 1, 1, 32'h80, 32'h200, 1, 32'h200, 0);
    n_cmp++; if (MispredictE !== 1'b0) begin n_err++; $display("FAIL jalr_correct got=%b exp=0", MispredictE); end
    tick(); idle_e(); #1;
    n_cmp++; if (BranchCount !== 32'd9) begin n_err++; $display("FAIL jalr_bcount got=%0d exp=9", BranchCount); end
    n_cmp++; if (MispredCount !== 32'd6) begin n_err++; $display("FAIL jalr_mcount got=%0d exp=6", MispredCount); end
  endtask

  task automatic test_alias();
    PCF = 32'h40;
    resolve(1, 0, 1, 32'h40, 32'h30, 0, 0, 0);   // hit, ctr 01 -> 10, target 0x30
    tick();
    resolve(1, 0, 1, 32'h140, 32'h300, 0, 0, 0); // miss at same index, overwrite
    n_cmp++; if (MispredictE !== 1'b1) begin n_err++; $display("FAIL alias_mispred got=%b exp=1", MispredictE); end
    n_cmp++; if (PredTargetF !== 32'h30) begin n_err++; $display("FAIL alias_pre got=%h exp=30", PredTargetF); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL alias_old_taken got=%b exp=0", PredTakenF); end
    n_cmp++; if (PredTargetF !== 32'h0) begin n_err++; $display("FAIL alias_old_target got=%h exp=0", PredTargetF); end
    PCF = 32'h140; #1;
    n_cmp++; if (PredTakenF !== 1'b1) begin n_err++; $display("FAIL alias_new_taken got=%b exp=1", PredTakenF); end
    n_cmp++; if (PredTargetF !== 32'h300) begin n_err++; $display("FAIL alias_new_target got=%h exp=300", PredTargetF); end
    n_cmp++; if (BranchCount !== 32'd11) begin n_err++; $display("FAIL alias_bcount got=%0d exp=11", BranchCount); end
    n_cmp++; if (MispredCount !== 32'd8) begin n_err++; $display("FAIL alias_mcount got=%0d exp=8", MispredCount); end
  endtask

  task automatic test_flush();
    PCF = 32'h140;
    resolve(1, 0, 0, 32'h140, 32'h300, 1, 32'h300, 1);
    n_cmp++; if (MispredictE !== 1'b0) begin n_err++; $display("FAIL flush_mispred got=%b exp=0", MispredictE); end
    tick(); idle_e(); #1;
    n_cmp++; if (PredTakenF !== 1'b1) begin n_err++; $display("FAIL flush_table got=%b exp=1", PredTakenF); end
    n_cmp++; if (BranchCount !== 32'd11) begin n_err++; $display("FAIL flush_bcount got=%0d exp=11", BranchCount); end
    n_cmp++; if (MispredCount !== 32'd8) begin n_err++; $display("FAIL flush_mcount got=%0d exp=8", MispredCount); end
  endtask

  task automatic test_reset_mid();
    PCF = 32'h140; reset = 1; #1;
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL rmid_during got=%b exp=0", PredTakenF); end
    tick(); reset = 0; #1;
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL rmid_taken got=%b exp=0", PredTakenF); end
    n_cmp++; if (PredTargetF !== 32'h0) begin n_err++; $display("FAIL rmid_target got=%h exp=0", PredTargetF); end
    PCF = 32'h80; #1;
    n_cmp++; if (PredTakenF !== 1'b0) begin n_err++; $display("FAIL rmid_jalr got=%b exp=0", PredTakenF); end
    n_cmp++; if (BranchCount !== 32'd0) begin n_err++; $display("FAIL rmid_bcount got=%0d exp=0", BranchCount); end
    n_cmp++; if (MispredCount !== 32'd0) begin n_err++; $display("FAIL rmid_mcount got=%0d exp=0", MispredCount); end
  endtask

  initial begin
    test_reset();
    test_branch_train();
    test_not_taken();
    test_jalr();
    test_alias();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch prediction and mispredict-recovery controller for the 5-stage pipelined RISC-V core.
- Predicts PC selection in Fetch from a direct-mapped BTB with a 2-bit saturating counter per entry.
- Trains the BTB when branches and jumps resolve in Execute.
- Raises MispredictE and supplies the corrected PC. The hazard unit ORs MispredictE into FlushD and FlushE.
- Replaces the static "predict not-taken, redirect on PCSrcE" scheme.

Parameters:
- IDX_W, 6, BTB index bits (2^IDX_W entries); index = PC[IDX_W+1:2]
- TAG_W, 8, tag bits; tag = PC[IDX_W+TAG_W+1:IDX_W+2]
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- PCF  in  32  Fetch PC
- PredTakenF  out  1  predict taken for PCF
- PredTargetF  out  32  predicted target for PCF
- BranchE  in  1  conditional branch in Execute
- JumpE  in  1  JAL/JALR in Execute
- TakenE  in  1  actual outcome (branch condition true, or jump)
- PCE  in  32  PC of the Execute instruction
- PCTargetE  in  32  actual target computed in Execute
- PCPlus4E  in  32  fall-through PC
- PredTakenE  in  1  PredTakenF carried down the pipeline
- PredTargetE  in  32  PredTargetF carried down the pipeline
- FlushE  in  1  Execute instruction is a bubble; suppresses resolve
- MispredictE  out  1  redirect required
- RedirectPCE  out  32  correct next PC
- BranchCount  out  CNT_W  resolved branches and jumps
- MispredCount  out  CNT_W  mispredictions

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous, active-high.
- Entry format: valid, tag[TAG_W], target[32], ctr[2].
- Reset: in the cycle reset is sampled high, all valid bits clear, all ctr go to 00, and BranchCount and MispredCount go to 0.
  - While reset is high, PredTakenF=0, PredTargetF=0, MispredictE=0, RedirectPCE=0.
- Lookup (combinational, zero latency from PCF):
  - hit = valid[idx] && tag[idx]==tagF.
  - PredTakenF = hit && ctr[idx][1].
  - PredTargetF = hit ? target[idx] : 0.
- Resolve (combinational): resolveE = (BranchE | JumpE) & ~FlushE.
  - MispredictE = resolveE && (PredTakenE != TakenE, or PredTakenE && TakenE && PredTargetE != PCTargetE).
  - RedirectPCE = TakenE ? PCTargetE : PCPlus4E.
- Update on the clk edge when resolveE=1, with index and tag taken from PCE:
  - Hit, taken: ctr saturating increment (11 holds); target <= PCTargetE.
  - Hit, not taken: ctr saturating decrement (00 holds); target unchanged.
  - Miss, taken: allocate (overwrite) with valid=1, tag, target=PCTargetE; ctr=11 for a jump, 10 for a branch.
  - Miss, not taken: no change.
- JALR is trained the same way as JAL. A changed JALR target is caught by the target compare.
- Simultaneous lookup and update of the same index: lookup sees the pre-update entry; the new value is visible the next cycle.
- Performance counters, on each edge:
  - BranchCount increments when resolveE=1.
  - MispredCount increments when MispredictE=1.
  - Both saturate at all-ones; no wrap.
- Stalls: the block has no stall input. The datapath holds PCF and the E-stage registers during a stall, so a stalled Execute instruction updates at most once. A stall with resolveE=1 held across multiple cycles is forbidden: the hazard unit must FlushE or guarantee a single-cycle E occupancy for branches.
- Reset mid-operation: table and counters clear; any in-flight prediction is discarded.

Decomposition:
- Shared package riscv_pkg holds:
  - BTB entry struct
  - CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11
  - function sat_update(ctr, taken)
- One sub-module, btb_table: the register array with one combinational read port and one synchronous write port plus synchronous clear.

Test Plan:
- Reset, then PCF=0x00000040 -> PredTakenF=0, PredTargetF=0; both counters 0.
- Branch at PCE=0x40, TakenE=1, PCTargetE=0x20, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x20. Next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x20 (ctr=10).
- Same branch resolves not-taken twice, PredTakenE matching each time -> first resolve gives MispredictE=1 (ctr 10->01), second gives MispredictE=0 (ctr 01->00). PCF=0x40 then predicts not-taken; MispredCount incremented by exactly 1 across the pair.
- JALR at PCE=0x80: first resolves to 0x100 (allocated, ctr=11); then resolves to 0x200 with PredTakenE=1, PredTargetE=0x100 -> MispredictE=1, RedirectPCE=0x200, entry target becomes 0x200.
- Alias PCs 0x40 and 0x40+(1<<(IDX_W+2)), both taken -> second overwrites the entry; PCF=0x40 then misses (PredTakenF=0).
- BranchE=1 with FlushE=1 -> MispredictE=0, no table or counter change. Assert reset mid-stream -> next-cycle lookup of a trained PC misses and counters read 0.
